// File: rtl/if_fetch.sv
// Instruction fetch stage: PC, IF/ID register and redirect/drain/halt FSM.
// Optional IF_PERF_CNT_EN adds saturating fetch and bubble counters.
module if_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000,
  parameter logic [3:0]  HLT_OP    = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        j_ctrl,
  input  logic [15:0] j_pc,
  input  logic        br_taken,
  input  logic [15:0] br_pc,
  input  logic        imem_rdy,
  input  logic [15:0] imem_instr,
  output logic        imem_re,
  output logic [15:0] imem_addr,
  output logic [15:0] instr,
  output logic [15:0] pc,
  output logic        valid,
  output logic        hlt_fetched
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    FETCH,
    DRAIN,
    HALT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pend_q, pend_d;
  logic [15:0] tgt;
  logic [15:0] instr_d, link_d;
  logic        valid_d, hlt_d;
  logic        ifid_ld;
  logic        accept;

  assign imem_re   = (state_q != HALT);
  assign imem_addr = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    tgt     = br_taken ? br_pc : j_pc;
    instr_d = NOP_INSTR;
    link_d  = pc;
    valid_d = 1'b0;
    hlt_d   = hlt_fetched;
    ifid_ld = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (br_taken || (j_ctrl && !stall)) begin
          ifid_ld = 1'b1;
          if (imem_rdy) begin
            pc_d = tgt;
          end else begin
            // request still in flight: park target until it returns
            pend_d  = tgt;
            state_d = DRAIN;
          end
        end else if (!stall) begin
          ifid_ld = 1'b1;
          if (imem_rdy) begin
            accept  = 1'b1;
            instr_d = imem_instr;
            link_d  = pc_q + 16'd1;
            valid_d = 1'b1;
            pc_d    = pc_q + 16'd1;
            if (imem_instr[15:12] == HLT_OP) begin
              state_d = HALT;
              hlt_d   = 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        if (br_taken) begin
          pend_d  = br_pc;
          ifid_ld = 1'b1;
        end else if (!stall) begin
          ifid_ld = 1'b1;
        end
        if (imem_rdy) begin
          pc_d    = br_taken ? br_pc : pend_q;
          state_d = FETCH;
        end
      end
      HALT: begin
        if (br_taken) begin
          pc_d    = br_pc;
          state_d = FETCH;
          hlt_d   = 1'b0;
          ifid_ld = 1'b1;
        end else if (!stall) begin
          ifid_ld = 1'b1;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      pend_q      <= RESET_PC;
      instr       <= NOP_INSTR;
      pc          <= 16'h0000;
      valid       <= 1'b0;
      hlt_fetched <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      hlt_fetched <= hlt_d;
      if (ifid_ld) begin
        instr <= instr_d;
        pc    <= link_d;
        valid <= valid_d;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt  <= 16'h0000;
      bubble_cnt <= 16'h0000;
    end else begin
      if (accept && fetch_cnt != 16'hFFFF)
        fetch_cnt <= fetch_cnt + 16'd1;
      if (!valid && state_q != HALT && bubble_cnt != 16'hFFFF)
        bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch.
// Memory returns 16'h1000+addr, or 16'hF000 at hlt_addr.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        j_ctrl = 1'b0;
  logic [15:0] j_pc = 16'h0;
  logic        br_taken = 1'b0;
  logic [15:0] br_pc = 16'h0;
  logic        imem_rdy = 1'b1;
  logic [15:0] imem_instr;
  logic        imem_re;
  logic [15:0] imem_addr;
  logic [15:0] instr;
  logic [15:0] pc;
  logic        valid;
  logic        hlt_fetched;
  logic [15:0] hlt_addr = 16'h0700;
`ifdef IF_PERF_CNT_EN
  logic [15:0] fetch_cnt;
  logic [15:0] bubble_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign imem_instr = (imem_addr == hlt_addr) ? 16'hF000
                                              : 16'h1000 + imem_addr;

  if_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .j_ctrl      (j_ctrl),
    .j_pc        (j_pc),
    .br_taken    (br_taken),
    .br_pc       (br_pc),
    .imem_rdy    (imem_rdy),
    .imem_instr  (imem_instr),
    .imem_re     (imem_re),
    .imem_addr   (imem_addr),
    .instr       (instr),
    .pc          (pc),
    .valid       (valid),
    .hlt_fetched (hlt_fetched)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .bubble_cnt  (bubble_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_valid", {15'd0, valid}, 16'd0);
    chk("rst_hlt", {15'd0, hlt_fetched}, 16'd0);
    chk("rst_re", {15'd0, imem_re}, 16'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // sequential fetch
    repeat (3) step();
    chk("seq_addr", imem_addr, 16'h0003);
    chk("seq_instr", instr, 16'h1002);
    chk("seq_pc", pc, 16'h0003);
    chk("seq_valid", {15'd0, valid}, 16'd1);

    // jump with same-cycle response
    j_ctrl = 1'b1; j_pc = 16'h0040;
    step();
    j_ctrl = 1'b0;
    chk("jmp_addr", imem_addr, 16'h0040);
    chk("jmp_valid", {15'd0, valid}, 16'd0);
    chk("jmp_instr", instr, 16'h0000);
    step();
    chk("jmp_fetch", instr, 16'h1040);
    chk("jmp_link", pc, 16'h0041);

    // branch beats jump and stall
    br_taken = 1'b1; br_pc = 16'h0080;
    j_ctrl = 1'b1; j_pc = 16'h0040; stall = 1'b1;
    step();
    br_taken = 1'b0; j_ctrl = 1'b0; stall = 1'b0;
    chk("prio_addr", imem_addr, 16'h0080);
    chk("prio_valid", {15'd0, valid}, 16'd0);
    chk("prio_instr", instr, 16'h0000);
    step();
    chk("br_fetch", instr, 16'h1080);

    // stall holds everything and drops the response
    stall = 1'b1;
    step();
    stall = 1'b0;
    chk("stall_addr", imem_addr, 16'h0081);
    chk("stall_instr", instr, 16'h1080);
    chk("stall_valid", {15'd0, valid}, 16'd1);

    // wait state inserts a bubble
    imem_rdy = 1'b0;
    step();
    chk("wait_valid", {15'd0, valid}, 16'd0);
    chk("wait_addr", imem_addr, 16'h0081);

    // branch during outstanding request drains it
    br_taken = 1'b1; br_pc = 16'h0020;
    step();
    br_taken = 1'b0;
    chk("drain_addr0", imem_addr, 16'h0081);
    chk("drain_re", {15'd0, imem_re}, 16'd1);
    step();
    chk("drain_addr1", imem_addr, 16'h0081);
    imem_rdy = 1'b1;
    step();
    chk("drain_tgt", imem_addr, 16'h0020);
    chk("drain_drop", {15'd0, valid}, 16'd0);
    step();
    chk("drain_fetch", instr, 16'h1020);

    // second branch in drain overwrites pending target
    imem_rdy = 1'b0; br_taken = 1'b1; br_pc = 16'h0050;
    step();
    br_pc = 16'h0060;
    step();
    br_taken = 1'b0; imem_rdy = 1'b1;
    step();
    chk("drain_ovr", imem_addr, 16'h0060);

    // PC wrap
    br_taken = 1'b1; br_pc = 16'hFFFF;
    step();
    br_taken = 1'b0;
    chk("wrap_addr0", imem_addr, 16'hFFFF);
    step();
    chk("wrap_instr", instr, 16'h0FFF);
    chk("wrap_pc", pc, 16'h0000);
    chk("wrap_addr1", imem_addr, 16'h0000);

    // halt
    hlt_addr = 16'h0005;
    br_taken = 1'b1; br_pc = 16'h0005;
    step();
    br_taken = 1'b0;
    step();
    chk("hlt_instr", instr, 16'hF000);
    chk("hlt_valid", {15'd0, valid}, 16'd1);
    chk("hlt_flag", {15'd0, hlt_fetched}, 16'd1);
    chk("hlt_re", {15'd0, imem_re}, 16'd0);
    step();
    chk("halt_valid", {15'd0, valid}, 16'd0);
    chk("halt_instr", instr, 16'h0000);
    j_ctrl = 1'b1; j_pc = 16'h0040;
    step();
    j_ctrl = 1'b0;
    chk("halt_jmp_re", {15'd0, imem_re}, 16'd0);
    br_taken = 1'b1; br_pc = 16'h0010;
    step();
    br_taken = 1'b0;
    chk("resume_re", {15'd0, imem_re}, 16'd1);
    chk("resume_addr", imem_addr, 16'h0010);
    chk("resume_hlt", {15'd0, hlt_fetched}, 16'd0);
    step();
    chk("resume_instr", instr, 16'h1010);

    // async reset mid-drain
    imem_rdy = 1'b0; br_taken = 1'b1; br_pc = 16'h0033;
    step();
    br_taken = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_addr", imem_addr, 16'h0000);
    chk("arst_instr", instr, 16'h0000);
    chk("arst_pc", pc, 16'h0000);
    chk("arst_valid", {15'd0, valid}, 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    imem_rdy = 1'b1;
    chk("arst_re", {15'd0, imem_re}, 16'd1);
    step();
    chk("post_instr", instr, 16'h1000);
    chk("post_pc", pc, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 16'h0000, meaning the bubble word driven to ID on squash or wait.
REQ-003 The block SHALL have parameter HLT_OP, default 4'hF, meaning the opcode (instr[15:12]) that ends fetch.
REQ-004 Ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- stall  in  1  hazard hold from ID; freezes PC and the IF/ID register.
- j_ctrl  in  1  ID-stage jump (jal/jr) taken this cycle.
- j_pc  in  16  jump target from ID.
- br_taken  in  1  EX-stage branch taken this cycle.
- br_pc  in  16  branch target from EX.
- imem_rdy  in  1  instruction memory response valid.
- imem_instr  in  16  instruction memory response data.
- imem_re  out  1  fetch request.
- imem_addr  out  16  fetch address; held stable until imem_rdy.
- instr  out  16  IF/ID instruction to ID.
- pc  out  16  IF/ID PC+1 of instr to ID (jal link value and jal base).
- valid  out  1  instr/pc hold a real fetched instruction.
- hlt_fetched  out  1  a HLT_OP instruction has been passed to ID.

Function
REQ-005 The FSM SHALL have states FETCH, DRAIN and HALT.
REQ-006 FETCH: imem_re=1 and imem_addr=PC; on imem_rdy with no redirect and no stall, instr<=imem_instr, pc<=PC+1, valid<=1, PC<=PC+1 (16-bit wrap, 16'hFFFF -> 16'h0000).
REQ-007 FETCH with imem_rdy=0 and no stall: the IF/ID register SHALL load NOP_INSTR, valid<=0; PC and imem_addr held.
REQ-008 stall=1 (no br_taken): PC, IF/ID, and FSM state held; any imem_rdy response this cycle SHALL be discarded and the same address re-fetched.
REQ-009 Redirect priority: br_taken > j_ctrl > stall > sequential; j_ctrl SHALL be ignored while stall=1.
REQ-010 Redirect with no request outstanding, or with imem_rdy=1 this cycle: PC<=target, IF/ID<=NOP_INSTR, valid<=0, state stays FETCH.
REQ-011 Redirect while a request is outstanding and imem_rdy=0: target SHALL be latched into pend_pc, state->DRAIN, IF/ID<=NOP_INSTR.
REQ-012 DRAIN: imem_re=1, imem_addr held at the old PC; on imem_rdy the data SHALL be dropped, PC<=pend_pc, state->FETCH; a later br_taken in DRAIN SHALL overwrite pend_pc.
REQ-013 When an accepted fetch has instr[15:12]==HLT_OP, the word SHALL pass to ID and state->HALT at the same edge; hlt_fetched<=1.
REQ-014 HALT: imem_re=0, IF/ID<=NOP_INSTR with valid=0 each unstalled cycle; br_taken SHALL exit to FETCH at br_pc (wrong-path HLT) and clear hlt_fetched; j_ctrl SHALL be ignored.
REQ-015 Latency: response accepted at edge N is visible on instr/pc/valid after edge N; a redirect at edge N puts the target on imem_addr after edge N (FETCH) or after the draining imem_rdy edge (DRAIN).

Reset
REQ-016 On rst_n low, asynchronously: PC=RESET_PC, pend_pc=RESET_PC, state=FETCH, instr=NOP_INSTR, pc=16'h0000, valid=0, hlt_fetched=0.
REQ-017 Reset during DRAIN SHALL abandon the outstanding request; the first post-reset fetch SHALL be from RESET_PC.
REQ-018 Outputs SHALL be stable and defined from the release of rst_n; no X on any output.

Configuration
REQ-019 Macro IF_PERF_CNT_EN SHALL, when defined, add outputs fetch_cnt[15:0] (accepted non-squashed fetches) and bubble_cnt[15:0] (cycles with valid=0 outside HALT), both reset to 0 and saturating at 16'hFFFF.
REQ-020 Without IF_PERF_CNT_EN, those ports and counters SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-021 Reset, imem_rdy=1 each cycle, memory addr k returns 16'h1000+k -> after 3 edges, imem_addr=3, instr=16'h1002, pc=3, valid=1.
REQ-022 j_ctrl=1, j_pc=16'h0040 with same-cycle imem_rdy -> next cycle imem_addr=16'h0040, valid=0, instr=NOP_INSTR.
REQ-023 br_taken=1, br_pc=16'h0080 and j_ctrl=1, j_pc=16'h0040 with stall=1 -> next imem_addr=16'h0080, IF/ID squashed.
REQ-024 imem_rdy held low 3 cycles, br_taken pulse to 16'h0020 in cycle 1 -> DRAIN; old data dropped on rdy; then imem_addr=16'h0020.
REQ-025 Fetch 16'hF000 -> instr=16'hF000, hlt_fetched=1, then imem_re=0 and valid=0 until br_taken to 16'h0010 resumes fetch.
REQ-026 rst_n pulsed low mid-DRAIN -> all outputs at reset values asynchronously; first fetch at RESET_PC.
